// File: rtl/snn_pkg.sv
// Shared spiking-core constants and the PE address type
// used by both the sensor event path and the AER transmit path.
package snn_pkg;

   localparam int NUM_PE    = 16;
   localparam int PE_ADDR_W = $clog2(NUM_PE);

   typedef logic [PE_ADDR_W-1:0] pe_addr_t;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous first-word-fall-through FIFO for encoded AER events.
// Head reads as zero while empty; storage itself is not reset.
module aer_event_fifo #(
   parameter  int DATA_W = 4,
   parameter  int DEPTH  = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spike_aer_tx.sv
// Collects per-PE spikes, arbitrates round-robin into an AER event FIFO,
// and acknowledges each accepted spike with a one-cycle spike_done pulse.
module spike_aer_tx
   import snn_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   parameter  int DROP_W     = 8,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 tx_en,
   input  logic [NUM_PE-1:0]    spike_in,
   output logic [NUM_PE-1:0]    spike_done,
   output logic                 evt_valid,
   output logic [PE_ADDR_W-1:0] evt_addr,
   input  logic                 evt_ready,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 pending_any,
   output logic [DROP_W-1:0]    drop_count
);

   localparam int LC_W = PE_ADDR_W + 1;

   logic [NUM_PE-1:0] pending;
   logic [NUM_PE-1:0] pending_next;
   logic [NUM_PE-1:0] gnt_oh;
   logic [NUM_PE-1:0] lost;
   pe_addr_t          rr;
   pe_addr_t          scan;
   pe_addr_t          gnt_idx;
   logic              gnt_hit;
   logic              grant;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LC_W-1:0]   lost_cnt;
   logic [DROP_W:0]   drop_sum;
   logic [DROP_W-1:0] drop_next;

   // First set pending bit at or after rr, wrapping modulo NUM_PE.
   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         scan = rr + pe_addr_t'(i);
         if (!gnt_hit && pending[scan]) begin
            gnt_hit = 1'b1;
            gnt_idx = scan;
         end
      end
   end

   assign grant  = tx_en && gnt_hit && !fifo_full;
   assign gnt_oh = grant ? (NUM_PE'(1) << gnt_idx) : '0;

   // A new spike on a still-pending, ungranted PE merges and is lost.
   assign lost         = spike_in & pending & ~gnt_oh;
   assign pending_next = (pending & ~gnt_oh) | spike_in;

   always_comb begin
      lost_cnt = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         lost_cnt = lost_cnt + LC_W'(lost[i]);
      end
   end

   assign drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(lost_cnt);
   assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pending    <= '0;
         rr         <= '0;
         spike_done <= '0;
         drop_count <= '0;
      end else begin
         pending    <= pending_next;
         spike_done <= gnt_oh;
         drop_count <= drop_next;
         if (grant) rr <= gnt_idx + pe_addr_t'(1);
      end
   end

   assign pending_any = |pending;
   assign evt_valid   = !fifo_empty;

   aer_event_fifo #(
      .DATA_W (PE_ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (grant),
      .push_data (gnt_idx),
      .pop       (evt_ready),
      .head      (evt_addr),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_spike_aer_tx.sv
// Self-checking bench for spike_aer_tx: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_spike_aer_tx;

   logic        clock;
   logic        reset_n;
   logic        tx_en;
   logic [15:0] spike_in;
   logic [15:0] spike_done;
   logic        evt_valid;
   logic [3:0]  evt_addr;
   logic        evt_ready;
   logic [3:0]  fifo_count;
   logic        pending_any;
   logic [7:0]  drop_count;

   int n_checks;
   int n_errors;

   bit [15:0] m_pend;
   int        m_rr;
   int        m_drop;
   int        m_q[$];
   bit [15:0] m_done;

   spike_aer_tx dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .tx_en       (tx_en),
      .spike_in    (spike_in),
      .spike_done  (spike_done),
      .evt_valid   (evt_valid),
      .evt_addr    (evt_addr),
      .evt_ready   (evt_ready),
      .fifo_count  (fifo_count),
      .pending_any (pending_any),
      .drop_count  (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock edge; the model steps from the pre-edge state
   // and inputs, then outputs are sampled 1 time unit after the edge.
   task automatic tick();
      bit g;
      int k;
      int lost;
      g = 0;
      k = 0;
      lost = 0;
      if (!reset_n) begin
         m_pend = '0;
         m_rr   = 0;
         m_drop = 0;
         m_q.delete();
         m_done = '0;
      end else begin
         if (tx_en && m_pend != 0 && m_q.size() < 8) begin
            for (int i = 0; i < 16; i++) begin
               if (!g && m_pend[(m_rr + i) % 16]) begin
                  g = 1;
                  k = (m_rr + i) % 16;
               end
            end
         end
         for (int i = 0; i < 16; i++) begin
            if (spike_in[i] && m_pend[i] && !(g && k == i)) lost++;
         end
         m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
         if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
         m_done = '0;
         if (g) begin
            m_q.push_back(k);
            m_rr = (k + 1) % 16;
            m_pend[k] = 1'b0;
            m_done[k] = 1'b1;
         end
         m_pend = m_pend | spike_in;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      tx_en     = 1'b1;
      evt_ready = 1'b1;
      spike_in  = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid: got %b want 0", evt_valid);
      end
      n_checks++;
      if (evt_addr !== 4'd0 || fifo_count !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_fifo: addr %0d count %0d want 0 0", evt_addr, fifo_count);
      end
      n_checks++;
      if (pending_any !== 1'b0 || drop_count !== 8'd0 || spike_done !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_state: pend %b drop %0d done %h want 0 0 0",
                  pending_any, drop_count, spike_done);
      end
   endtask

   task automatic test_single();
      do_reset();
      spike_in = 16'h0020;
      tick();
      spike_in = '0;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_addr !== 4'd5) begin
         n_errors++;
         $display("FAIL single_event: valid %b addr %0d want 1 5", evt_valid, evt_addr);
      end
      n_checks++;
      if (spike_done !== 16'h0020) begin
         n_errors++;
         $display("FAIL single_done: got %h want 0020", spike_done);
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b0 || spike_done !== 16'h0 || drop_count !== 8'd0) begin
         n_errors++;
         $display("FAIL single_after: valid %b done %h drop %0d want 0 0 0",
                  evt_valid, spike_done, drop_count);
      end
   endtask

   task automatic test_burst();
      do_reset();
      spike_in = 16'hFFFF;
      tick();
      spike_in = '0;
      tick();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (evt_valid !== 1'b1 || evt_addr !== 4'(i)) begin
            n_errors++;
            $display("FAIL burst_addr%0d: valid %b addr %0d want 1 %0d",
                     i, evt_valid, evt_addr, i);
         end
         n_checks++;
         if (pending_any !== (i < 15)) begin
            n_errors++;
            $display("FAIL burst_pend%0d: got %b want %b", i, pending_any, i < 15);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int got;
      do_reset();
      evt_ready = 1'b0;
      spike_in  = 16'hFFFF;
      tick();
      spike_in = '0;
      for (int c = 0; c < 12; c++) tick();
      n_checks++;
      if (fifo_count !== 4'd8 || evt_addr !== 4'd0 || pending_any !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_full: count %0d addr %0d pend %b want 8 0 1",
                  fifo_count, evt_addr, pending_any);
      end
      n_checks++;
      if (spike_done !== 16'h0) begin
         n_errors++;
         $display("FAIL bp_nopush: done %h want 0000", spike_done);
      end
      evt_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 16; c++) begin
         if (evt_valid) begin
            n_checks++;
            if (evt_addr !== 4'(got)) begin
               n_errors++;
               $display("FAIL bp_order%0d: got %0d want %0d", got, evt_addr, got);
            end
            got++;
         end
         tick();
      end
      n_checks++;
      if (got != 16 || drop_count !== 8'd0) begin
         n_errors++;
         $display("FAIL bp_drain: events %0d drop %0d want 16 0", got, drop_count);
      end
   endtask

   task automatic test_drop();
      int exp_list[9];
      int got;
      for (int i = 0; i < 8; i++) exp_list[i] = i;
      exp_list[8] = 3;
      do_reset();
      evt_ready = 1'b0;
      spike_in  = 16'h00FF;
      tick();
      spike_in = '0;
      for (int c = 0; c < 9; c++) tick();
      spike_in = 16'h0008;
      tick();
      spike_in = '0;
      tick();
      spike_in = 16'h0008;
      tick();
      spike_in = '0;
      tick();
      n_checks++;
      if (drop_count !== 8'd1 || fifo_count !== 4'd8) begin
         n_errors++;
         $display("FAIL drop_count: drop %0d count %0d want 1 8", drop_count, fifo_count);
      end
      evt_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 9; c++) begin
         if (evt_valid) begin
            n_checks++;
            if (evt_addr !== 4'(exp_list[got])) begin
               n_errors++;
               $display("FAIL drop_order%0d: got %0d want %0d",
                        got, evt_addr, exp_list[got]);
            end
            got++;
         end
         tick();
      end
      tick();
      n_checks++;
      if (got != 9 || evt_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL drop_drain: events %0d valid %b want 9 0", got, evt_valid);
      end
   endtask

   task automatic test_round_robin();
      int got;
      do_reset();
      spike_in = 16'h0003;
      got = 0;
      for (int c = 0; c < 30 && got < 8; c++) begin
         tick();
         if (evt_valid) begin
            n_checks++;
            if (evt_addr !== 4'(got % 2)) begin
               n_errors++;
               $display("FAIL rr_alt%0d: got %0d want %0d", got, evt_addr, got % 2);
            end
            got++;
         end
      end
      spike_in = '0;
      n_checks++;
      if (got != 8) begin
         n_errors++;
         $display("FAIL rr_timeout: events %0d want 8", got);
      end
      n_checks++;
      if (drop_count !== 8'(m_drop)) begin
         n_errors++;
         $display("FAIL rr_drop: got %0d want %0d", drop_count, m_drop);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      tx_en     = 1'b0;
      evt_ready = 1'b0;
      spike_in  = 16'hFFFF;
      for (int c = 0; c < 18; c++) tick();
      n_checks++;
      if (drop_count !== 8'd255) begin
         n_errors++;
         $display("FAIL sat_drop: got %0d want 255", drop_count);
      end
      n_checks++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0 || pending_any !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_txoff: count %0d valid %b pend %b want 0 0 1",
                  fifo_count, evt_valid, pending_any);
      end
      spike_in = '0;
      tx_en    = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      evt_ready = 1'b0;
      spike_in  = 16'h01FF;
      tick();
      spike_in = '0;
      for (int c = 0; c < 5; c++) tick();
      n_checks++;
      if (fifo_count !== 4'd5 || pending_any !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_setup: count %0d pend %b want 5 1", fifo_count, pending_any);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_checks++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0 || pending_any !== 1'b0 ||
          drop_count !== 8'd0 || spike_done !== 16'h0) begin
         n_errors++;
         $display("FAIL mid_cleared: count %0d valid %b pend %b drop %0d done %h want all 0",
                  fifo_count, evt_valid, pending_any, drop_count, spike_done);
      end
      evt_ready = 1'b1;
      spike_in  = 16'h0200;
      tick();
      spike_in = '0;
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_early: valid %b want 0", evt_valid);
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_addr !== 4'd9 || spike_done !== 16'h0200) begin
         n_errors++;
         $display("FAIL mid_event: valid %b addr %0d done %h want 1 9 0200",
                  evt_valid, evt_addr, spike_done);
      end
   endtask

   task automatic test_random();
      int exp_addr;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         spike_in  = 16'($urandom & $urandom & $urandom);
         tx_en     = ($urandom_range(0, 7) != 0);
         evt_ready = 1'($urandom_range(0, 1));
         tick();
         exp_addr = (m_q.size() != 0) ? m_q[0] : 0;
         n_checks++;
         if (evt_valid !== (m_q.size() != 0) || evt_addr !== 4'(exp_addr)) begin
            n_errors++;
            $display("FAIL rand_head c%0d: valid %b addr %0d want %b %0d",
                     c, evt_valid, evt_addr, m_q.size() != 0, exp_addr);
         end
         n_checks++;
         if (fifo_count !== 4'(m_q.size())) begin
            n_errors++;
            $display("FAIL rand_count c%0d: got %0d want %0d", c, fifo_count, m_q.size());
         end
         n_checks++;
         if (pending_any !== (m_pend != 0) || spike_done !== m_done) begin
            n_errors++;
            $display("FAIL rand_pend c%0d: pend %b done %h want %b %h",
                     c, pending_any, spike_done, m_pend != 0, m_done);
         end
         n_checks++;
         if (drop_count !== 8'(m_drop)) begin
            n_errors++;
            $display("FAIL rand_drop c%0d: got %0d want %0d", c, drop_count, m_drop);
         end
      end
      spike_in = '0;
      tx_en    = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset_n   = 1'b0;
      tx_en     = 1'b0;
      evt_ready = 1'b0;
      spike_in  = '0;
      m_pend    = '0;
      m_rr      = 0;
      m_drop    = 0;
      m_done    = '0;
      #2;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_drop();
      test_round_robin();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
